// File: rtl/row_mem_load_sched.sv
// Row-memory loader sequencer: latches a job config, streams act/weight SRAM words into the
// loader tile by tile, and hands each loaded tile to the PE array.
module row_mem_load_sched #(
  parameter int unsigned ACT_ADDR_W = 11,
  parameter int unsigned WGT_ADDR_W = 9,
  parameter int unsigned INPUT_BW   = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cfg_valid,
  input  logic [5:0]            cfg_oc,
  input  logic [5:0]            cfg_img_h,
  input  logic [5:0]            cfg_img_w,
  input  logic [2:0]            cfg_k,
  input  logic [5:0]            cfg_num_tiles,
  output logic                  busy,
  output logic                  job_done,
  output logic                  err_cfg,
  output logic                  act_sram_en,
  output logic [ACT_ADDR_W-1:0] act_sram_addr,
  input  logic [INPUT_BW-1:0]   act_sram_rdata,
  output logic                  wgt_sram_en,
  output logic [WGT_ADDR_W-1:0] wgt_sram_addr,
  input  logic [INPUT_BW-1:0]   wgt_sram_rdata,
  output logic                  ld_start,
  output logic [INPUT_BW-1:0]   ld_act_data,
  output logic [ACT_ADDR_W-1:0] ld_act_addr,
  output logic [INPUT_BW-1:0]   ld_wgt_data,
  output logic [WGT_ADDR_W-1:0] ld_wgt_addr,
  input  logic                  ld_done,
  output logic                  tile_valid,
  input  logic                  pe_ready
);

  localparam logic [11:0] ActMax = 12'((1 << ACT_ADDR_W) - 1);
  localparam logic [11:0] WgtMax = 12'((1 << WGT_ADDR_W) - 1);

  typedef enum logic [2:0] {
    StIdle, StCalc, StStart, StStream, StWaitDone, StHandoff, StDone
  } state_e;

  state_e state_q, state_d;

  logic [5:0]            oc_q, oc_d, img_h_q, img_h_d, img_w_q, img_w_d;
  logic [2:0]            k_q, k_d;
  logic [5:0]            num_tiles_q, num_tiles_d, tile_idx_q, tile_idx_d;
  logic                  err_cfg_q, err_cfg_d;
  logic [11:0]           act_cnt_q, act_cnt_d, wgt_cnt_q, wgt_cnt_d;
  logic [11:0]           ai_q, ai_d, wi_q, wi_d;
  logic [ACT_ADDR_W-1:0] act_base_q, act_base_d, ld_act_addr_q, ld_act_addr_d;
  logic [WGT_ADDR_W-1:0] wgt_base_q, wgt_base_d, ld_wgt_addr_q, ld_wgt_addr_d;
  logic                  ld_done_seen_q, ld_done_seen_d;
  logic                  act_vld_q, wgt_vld_q;

  logic [11:0] act_dim_h, act_dim_w, act_cnt_calc, wgt_cnt_calc;
  logic        cfg_bad, act_pend, wgt_pend, stream_end, last_tile, handshake;

  always_comb begin
    act_dim_h    = 12'(img_h_q) + 12'(k_q) - 12'd1;
    act_dim_w    = 12'(img_w_q) + 12'(k_q) - 12'd1;
    act_cnt_calc = act_dim_h * act_dim_w;
    wgt_cnt_calc = 12'(k_q) * 12'(k_q) * 12'(oc_q);
    cfg_bad      = !((k_q == 3'd1) || (k_q == 3'd3)) || (num_tiles_q == 6'd0) ||
                   (act_cnt_calc > ActMax) || (wgt_cnt_calc > WgtMax);
    act_pend     = ai_q < act_cnt_q;
    wgt_pend     = wi_q < wgt_cnt_q;
    stream_end   = !act_pend && !wgt_pend;
    last_tile    = tile_idx_q == (num_tiles_q - 6'd1);
    handshake    = (state_q == StHandoff) && pe_ready;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (cfg_valid) state_d = StCalc;
      StCalc:     state_d = cfg_bad ? StDone : StStart;
      StStart:    state_d = StStream;
      // A loader done seen while streaming skips the wait state.
      StStream:   if (stream_end) state_d = (ld_done_seen_q || ld_done) ? StHandoff : StWaitDone;
      StWaitDone: if (ld_done) state_d = StHandoff;
      StHandoff:  if (pe_ready) state_d = last_tile ? StDone : StStart;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    busy          = state_q != StIdle;
    job_done      = state_q == StDone;
    ld_start      = state_q == StStart;
    tile_valid    = state_q == StHandoff;
    err_cfg       = err_cfg_q;
    act_sram_en   = (state_q == StStream) && act_pend;
    wgt_sram_en   = (state_q == StStream) && wgt_pend;
    act_sram_addr = act_sram_en ? act_base_q + ai_q[ACT_ADDR_W-1:0] : '0;
    wgt_sram_addr = wgt_sram_en ? wgt_base_q + wi_q[WGT_ADDR_W-1:0] : '0;
    ld_act_data   = act_vld_q ? act_sram_rdata : '0;
    ld_wgt_data   = wgt_vld_q ? wgt_sram_rdata : '0;
    ld_act_addr   = ld_act_addr_q;
    ld_wgt_addr   = ld_wgt_addr_q;
  end

  always_comb begin
    oc_d           = oc_q;
    img_h_d        = img_h_q;
    img_w_d        = img_w_q;
    k_d            = k_q;
    num_tiles_d    = num_tiles_q;
    err_cfg_d      = err_cfg_q;
    act_cnt_d      = act_cnt_q;
    wgt_cnt_d      = wgt_cnt_q;
    tile_idx_d     = tile_idx_q;
    act_base_d     = act_base_q;
    wgt_base_d     = wgt_base_q;
    ai_d           = ai_q;
    wi_d           = wi_q;
    ld_done_seen_d = ld_done_seen_q;
    // The index counters double as the loader address: terminal count persists after a pass.
    ld_act_addr_d  = ai_q[ACT_ADDR_W-1:0];
    ld_wgt_addr_d  = wi_q[WGT_ADDR_W-1:0];
    if ((state_q == StIdle) && cfg_valid) begin
      oc_d        = cfg_oc;
      img_h_d     = cfg_img_h;
      img_w_d     = cfg_img_w;
      k_d         = cfg_k;
      num_tiles_d = cfg_num_tiles;
      err_cfg_d   = 1'b0;
    end
    if (state_q == StCalc) begin
      act_cnt_d  = act_cnt_calc;
      wgt_cnt_d  = wgt_cnt_calc;
      tile_idx_d = '0;
      act_base_d = '0;
      wgt_base_d = '0;
      if (cfg_bad) err_cfg_d = 1'b1;
    end
    if (state_q == StStart) begin
      ai_d           = '0;
      wi_d           = '0;
      ld_done_seen_d = 1'b0;
    end
    if (state_q == StStream) begin
      if (act_pend) ai_d = ai_q + 12'd1;
      if (wgt_pend) wi_d = wi_q + 12'd1;
      ld_done_seen_d = ld_done_seen_q || ld_done;
    end
    if (handshake) begin
      act_base_d = act_base_q + act_cnt_q[ACT_ADDR_W-1:0];
      wgt_base_d = wgt_base_q + wgt_cnt_q[WGT_ADDR_W-1:0];
      tile_idx_d = tile_idx_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oc_q           <= '0;
      img_h_q        <= '0;
      img_w_q        <= '0;
      k_q            <= '0;
      num_tiles_q    <= '0;
      err_cfg_q      <= 1'b0;
      act_cnt_q      <= '0;
      wgt_cnt_q      <= '0;
      tile_idx_q     <= '0;
      act_base_q     <= '0;
      wgt_base_q     <= '0;
      ai_q           <= '0;
      wi_q           <= '0;
      ld_done_seen_q <= 1'b0;
      ld_act_addr_q  <= '0;
      ld_wgt_addr_q  <= '0;
      act_vld_q      <= 1'b0;
      wgt_vld_q      <= 1'b0;
    end else begin
      oc_q           <= oc_d;
      img_h_q        <= img_h_d;
      img_w_q        <= img_w_d;
      k_q            <= k_d;
      num_tiles_q    <= num_tiles_d;
      err_cfg_q      <= err_cfg_d;
      act_cnt_q      <= act_cnt_d;
      wgt_cnt_q      <= wgt_cnt_d;
      tile_idx_q     <= tile_idx_d;
      act_base_q     <= act_base_d;
      wgt_base_q     <= wgt_base_d;
      ai_q           <= ai_d;
      wi_q           <= wi_d;
      ld_done_seen_q <= ld_done_seen_d;
      ld_act_addr_q  <= ld_act_addr_d;
      ld_wgt_addr_q  <= ld_wgt_addr_d;
      act_vld_q      <= act_sram_en;
      wgt_vld_q      <= wgt_sram_en;
    end
  end

endmodule

// File: tb/tb_row_mem_load_sched.sv
// Scoreboard bench for row_mem_load_sched: SRAM, loader and PE models plus expected-read queues.
module tb_row_mem_load_sched;

  localparam int ActW = 11;
  localparam int WgtW = 9;
  localparam int Bw   = 8;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            cfg_valid = 1'b0;
  logic [5:0]      cfg_oc = '0, cfg_img_h = '0, cfg_img_w = '0, cfg_num_tiles = '0;
  logic [2:0]      cfg_k = '0;
  logic            busy, job_done, err_cfg;
  logic            act_sram_en, wgt_sram_en;
  logic [ActW-1:0] act_sram_addr, ld_act_addr;
  logic [WgtW-1:0] wgt_sram_addr, ld_wgt_addr;
  logic [Bw-1:0]   act_sram_rdata = '0, wgt_sram_rdata = '0, ld_act_data, ld_wgt_data;
  logic            ld_start, ld_done = 1'b0, tile_valid, pe_ready = 1'b0;

  row_mem_load_sched #(.ACT_ADDR_W(ActW), .WGT_ADDR_W(WgtW), .INPUT_BW(Bw)) dut (
    .clk(clk), .resetn(resetn), .cfg_valid(cfg_valid), .cfg_oc(cfg_oc),
    .cfg_img_h(cfg_img_h), .cfg_img_w(cfg_img_w), .cfg_k(cfg_k),
    .cfg_num_tiles(cfg_num_tiles), .busy(busy), .job_done(job_done), .err_cfg(err_cfg),
    .act_sram_en(act_sram_en), .act_sram_addr(act_sram_addr), .act_sram_rdata(act_sram_rdata),
    .wgt_sram_en(wgt_sram_en), .wgt_sram_addr(wgt_sram_addr), .wgt_sram_rdata(wgt_sram_rdata),
    .ld_start(ld_start), .ld_act_data(ld_act_data), .ld_act_addr(ld_act_addr),
    .ld_wgt_data(ld_wgt_data), .ld_wgt_addr(ld_wgt_addr), .ld_done(ld_done),
    .tile_valid(tile_valid), .pe_ready(pe_ready)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  int        act_a_q[$], act_i_q[$], wgt_a_q[$], wgt_i_q[$];
  logic [7:0] act_d_q[$], wgt_d_q[$];

  int j_mx = 0, ld_delay = 1, pe_delay = 0;
  int n_start = 0, n_done = 0, n_rd = 0;
  int first_start = -1, first_rd = -1, first_ld = -1;
  int s_cyc = 0, d_cyc = -1, ld_done_at = -1, tv_run = 0;
  bit tv_prev = 0, start_pend = 0, a_en_p = 0, w_en_p = 0;
  int a_addr_s = 0, w_addr_s = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] act_word(input int a);
    return 8'(a * 3 + 1);
  endfunction

  function automatic logic [7:0] wgt_word(input int a);
    return 8'(a * 5 + 7) ^ 8'hC3;
  endfunction

  // SRAM (1-cycle read latency), loader done and PE ready models.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    ld_done        = resetn && (cyc == ld_done_at);
    pe_ready       = tv_run >= pe_delay;
    act_sram_rdata = a_en_p ? act_word(a_addr_s) : 8'hEE;
    wgt_sram_rdata = w_en_p ? wgt_word(w_addr_s) : 8'hEE;
  end

  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      a_en_p = 0; w_en_p = 0; tv_run = 0; tv_prev = 0; start_pend = 0;
    end else begin
      if (a_en_p) begin
        if (first_ld < 0) first_ld = cyc;
        check_eq("act_ld_expected", act_i_q.size() > 0, 1);
        if (act_i_q.size() > 0) begin
          check_eq("ld_act_addr", ld_act_addr, act_i_q.pop_front());
          check_eq("ld_act_data", ld_act_data, act_d_q.pop_front());
        end
      end
      if (w_en_p) begin
        check_eq("wgt_ld_expected", wgt_i_q.size() > 0, 1);
        if (wgt_i_q.size() > 0) begin
          check_eq("ld_wgt_addr", ld_wgt_addr, wgt_i_q.pop_front());
          check_eq("ld_wgt_data", ld_wgt_data, wgt_d_q.pop_front());
        end
      end
      if (act_sram_en || wgt_sram_en) begin
        n_rd++;
        if (first_rd < 0) first_rd = cyc;
        check_eq("rd_while_busy", busy, 1);
        check_eq("rd_during_handoff", tile_valid, 0);
      end
      if (act_sram_en) begin
        check_eq("act_rd_expected", act_a_q.size() > 0, 1);
        if (act_a_q.size() > 0) check_eq("act_sram_addr", act_sram_addr, act_a_q.pop_front());
      end
      if (wgt_sram_en) begin
        check_eq("wgt_rd_expected", wgt_a_q.size() > 0, 1);
        if (wgt_a_q.size() > 0) check_eq("wgt_sram_addr", wgt_sram_addr, wgt_a_q.pop_front());
      end
      a_en_p = act_sram_en; a_addr_s = act_sram_addr;
      w_en_p = wgt_sram_en; w_addr_s = wgt_sram_addr;
      if (tile_valid && !tv_prev)
        check_eq("handoff_cyc", cyc, (s_cyc + 2 + j_mx > d_cyc + 1) ? s_cyc + 2 + j_mx : d_cyc + 1);
      if (tile_valid) tv_run++;
      else begin
        if (tv_prev) begin
          check_eq("tile_valid_len", tv_run, pe_delay + 1);
          check_eq("after_handshake", ld_start || job_done, 1);
        end
        tv_run = 0;
      end
      tv_prev = tile_valid;
      if (ld_start) begin
        n_start++;
        check_eq("ld_start_unpaired", start_pend, 0);
        start_pend = 1;
        if (first_start < 0) first_start = cyc;
        s_cyc = cyc; d_cyc = -1; ld_done_at = cyc + ld_delay;
      end
      if (ld_done) begin start_pend = 0; d_cyc = cyc; end
      if (job_done) n_done++;
    end
  end

  task automatic run_job(input logic [5:0] oc, input logic [5:0] h, input logic [5:0] w,
                         input logic [2:0] k, input logic [5:0] nt, input int lddly,
                         input int pedly, input bit exp_err, input bit inject, input int rst_at);
    int ac, wc, t, done_cyc;
    bit got;
    ac = ((int'(h) + int'(k) - 1) * (int'(w) + int'(k) - 1)) % 4096;
    wc = int'(k) * int'(k) * int'(oc);
    j_mx = (ac > wc) ? ac : wc;
    ld_delay = lddly; pe_delay = pedly;
    n_start = 0; n_done = 0; n_rd = 0; first_start = -1; first_rd = -1; first_ld = -1;
    if (!exp_err)
      for (int tl = 0; tl < int'(nt); tl++) begin
        for (int i = 0; i < ac; i++) begin
          act_a_q.push_back((tl * ac + i) % 2048); act_i_q.push_back(i);
          act_d_q.push_back(act_word((tl * ac + i) % 2048));
        end
        for (int i = 0; i < wc; i++) begin
          wgt_a_q.push_back((tl * wc + i) % 512); wgt_i_q.push_back(i);
          wgt_d_q.push_back(wgt_word((tl * wc + i) % 512));
        end
      end
    @(posedge clk); #1;
    cfg_valid = 1; cfg_oc = oc; cfg_img_h = h; cfg_img_w = w; cfg_k = k; cfg_num_tiles = nt;
    t = cyc;
    @(posedge clk); #1;
    cfg_valid = 0;
    cfg_oc = 6'($urandom); cfg_img_h = 6'($urandom); cfg_img_w = 6'($urandom);
    cfg_k = 3'($urandom); cfg_num_tiles = 6'($urandom);
    @(negedge clk);
    check_eq("busy_in_calc", busy, 1);
    check_eq("err_cleared", err_cfg, 0);
    got = 0; done_cyc = 0;
    for (int i = 0; i < 20000 && !got; i++) begin
      if (job_done) begin got = 1; done_cyc = cyc; end
      else begin
        if (rst_at > 0 && cyc == t + rst_at) begin
          resetn = 0;
          @(negedge clk);
          check_eq("rst_ctrl", {busy, job_done, err_cfg, act_sram_en, wgt_sram_en, ld_start,
                                tile_valid}, 0);
          check_eq("rst_sram_addr", {act_sram_addr, wgt_sram_addr}, 0);
          check_eq("rst_ld_addr", {ld_act_addr, ld_wgt_addr}, 0);
          check_eq("rst_ld_data", {ld_act_data, ld_wgt_data}, 0);
          act_a_q.delete(); act_i_q.delete(); act_d_q.delete();
          wgt_a_q.delete(); wgt_i_q.delete(); wgt_d_q.delete();
          ld_done_at = -1;
          @(negedge clk);
          resetn = 1;
          @(negedge clk);
          check_eq("rst_idle", busy, 0);
          return;
        end
        cfg_valid = inject && (cyc == t + 6);
        if (cfg_valid) begin cfg_k = 3'd1; cfg_oc = 6'd5; cfg_num_tiles = 6'd1; end
        @(negedge clk);
      end
    end
    cfg_valid = 0;
    check_eq("job_done_seen", got, 1);
    if (exp_err) begin
      check_eq("err_done_cyc", done_cyc, t + 2);
      check_eq("err_flag", err_cfg, 1);
      check_eq("err_no_start", n_start, 0);
      check_eq("err_no_reads", n_rd, 0);
    end else begin
      check_eq("start_cyc", first_start, t + 2);
      check_eq("first_rd_cyc", first_rd, t + 3);
      check_eq("first_ld_cyc", first_ld, t + 4);
      check_eq("n_ld_start", n_start, nt);
      check_eq("err_flag", err_cfg, 0);
      check_eq("sb_drained", act_a_q.size() + act_i_q.size() + wgt_a_q.size() + wgt_i_q.size(), 0);
      check_eq("ld_act_term", ld_act_addr, ac);
      check_eq("ld_wgt_term", ld_wgt_addr, wc);
      check_eq("ld_data_term", {ld_act_data, ld_wgt_data}, 0);
    end
    @(negedge clk);
    check_eq("idle_after_done", busy, 0);
    check_eq("err_sticky", err_cfg, exp_err);
    @(negedge clk);
    check_eq("n_job_done", n_done, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_ctrl", {busy, job_done, err_cfg, act_sram_en, wgt_sram_en, ld_start,
                            tile_valid}, 0);
    check_eq("reset_ld_addr", {ld_act_addr, ld_wgt_addr}, 0);
    resetn = 1;
    @(negedge clk);
    check_eq("idle_after_reset", busy, 0);
    //      oc  h   w   k  nt lddly pe err inj rst
    run_job(4,  4,  4,  1, 1, 22,   0, 0,  0,  0);
    run_job(2,  2,  2,  3, 3, 3,    0, 0,  1,  0);
    run_job(63, 2,  2,  3, 1, 3,    0, 1,  0,  0);
    run_job(4,  4,  4,  2, 1, 3,    0, 1,  0,  0);
    run_job(57, 2,  2,  3, 1, 3,    0, 1,  0,  0);
    run_job(56, 2,  2,  3, 1, 3,    0, 0,  0,  0);
    run_job(1,  63, 63, 1, 1, 3,    0, 1,  0,  0);
    run_job(1,  2,  2,  1, 0, 3,    0, 1,  0,  0);
    run_job(1,  2,  2,  1, 2, 2,    10, 0, 0,  0);
    run_job(56, 14, 14, 3, 9, 3,    0, 0,  0,  0);
    run_job(4,  4,  4,  1, 1, 30,   0, 0,  0,  8);
    run_job(2,  2,  2,  3, 2, 3,    1, 0,  0,  0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/row_mem_load_sched.md
# row_mem_load_sched

Sequencer that drives the row-memory loader for one convolution job. It latches a layer configuration, streams activation and weight words from the global act/weight SRAMs into the loader, and waits for the loader's done. It then hands each loaded tile to the PE array through a valid/ready handshake, repeating for a configured number of tiles. It sits between the top-level job controller, the global SRAMs, the row-memory loader and the PE array.

## Interface
- ACT_ADDR_W, 11, width of activation SRAM address and loader act address
- WGT_ADDR_W, 9, width of weight SRAM address and loader weight address
- INPUT_BW, 8, data word width (signed)
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  job start pulse; config sampled same cycle; accepted only in IDLE
- cfg_oc / cfg_img_h / cfg_img_w  in  6 each  output channels, output height, output width
- cfg_k  in  3  kernel size; legal values 1 and 3
- cfg_num_tiles  in  6  loader passes per job; legal range 1..63
- busy  out  1  high in every state except IDLE
- job_done  out  1  one-cycle pulse at job end (normal or error)
- err_cfg  out  1  sticky illegal-config flag; cleared by the next accepted cfg_valid
- act_sram_en / act_sram_addr  out  1 / ACT_ADDR_W  act SRAM read; data returns next cycle
- act_sram_rdata  in  INPUT_BW  act SRAM read data
- wgt_sram_en / wgt_sram_addr  out  1 / WGT_ADDR_W  weight SRAM read; 1-cycle latency
- wgt_sram_rdata  in  INPUT_BW  weight SRAM read data
- ld_start  out  1  one-cycle start pulse to loader
- ld_act_data / ld_act_addr  out  INPUT_BW / ACT_ADDR_W  act stream to loader (tile-local index)
- ld_wgt_data / ld_wgt_addr  out  INPUT_BW / WGT_ADDR_W  weight stream to loader
- ld_done  in  1  loader finished pulse
- tile_valid  out  1  loaded tile ready for compute
- pe_ready  in  1  PE array accepts tile

## Operation
- States: IDLE, CALC, START, STREAM, WAIT_DONE, HANDOFF, DONE.
- IDLE: on cfg_valid, latch config, clear err_cfg, go to CALC. cfg_valid in any other state is ignored.
- CALC (1 cycle): compute act_cnt = (H+K-1)*(W+K-1) in 12 bits and wgt_cnt = K*K*OC in 12 bits.
  - Error if K∉{1,3}, num_tiles==0, act_cnt > 2^ACT_ADDR_W−1, or wgt_cnt > 2^WGT_ADDR_W−1.
  - On error: set err_cfg and go to DONE; no ld_start and no SRAM read is issued.
  - Otherwise clear tile_idx, act_base and wgt_base, then go to START.
- START (1 cycle): ld_start=1; clear local counters ai and wi; go to STREAM.
- STREAM: act and weight streams run concurrently and independently.
  - Each cycle with ai<act_cnt: act_sram_en=1, act_sram_addr=act_base+ai (mod 2^ACT_ADDR_W), then ai++.
  - Weights follow the same rule with wi, wgt_cnt and wgt_base.
  - Leave STREAM when both ai==act_cnt and wi==wgt_cnt; go to WAIT_DONE.
- Loader-side outputs are registered from the SRAM read pipeline:
  - ld_act_addr = index of the word on ld_act_data.
  - After the last word, ld_act_addr holds terminal value act_cnt with ld_act_data=0 until the next START.
  - ld_wgt_addr/ld_wgt_data behave the same way, with terminal value wgt_cnt.
- WAIT_DONE: on ld_done, go to HANDOFF. If ld_done arrives during STREAM, it is recorded and honoured as soon as both streams finish.
- HANDOFF: tile_valid=1 until the cycle tile_valid&&pe_ready.
  - On that cycle: act_base+=act_cnt, wgt_base+=wgt_cnt, tile_idx++.
  - If tile_idx==num_tiles−1, go to DONE; else go to START.
- DONE (1 cycle): job_done=1; go to IDLE.

## Timing
- Reset value of every output is 0, including the ld_* addresses and err_cfg.
- Reset mid-job returns to IDLE immediately with no pulse emitted.
- cfg_valid at cycle t: CALC at t+1, ld_start at t+2, first SRAM read at t+3, first ld_act_data/ld_act_addr=0 at t+4.
- Last act read at t+2+act_cnt; ld_act_addr=act_cnt from t+4+act_cnt onward.
- Error path: cfg_valid at t, job_done and err_cfg=1 at t+2.
- SRAM en is never asserted outside STREAM.
- ld_start is never asserted twice without an intervening ld_done.
- Base addresses wrap modulo 2^ACT_ADDR_W and 2^WGT_ADDR_W.
- pe_ready high on the cycle HANDOFF is entered: handshake completes that cycle, and the next START follows on the next cycle.

## Test plan
- K=1, H=W=4, OC=4, tiles=1: act reads addr 0..15 and weight reads 0..3; ld_act_addr ends holding 16, ld_wgt_addr holds 4. Drive ld_done 5 cycles later, pe_ready=1; expect tile_valid for 1 cycle, then job_done.
- K=3, H=W=2, OC=2, tiles=3: act_cnt=16, wgt_cnt=18. Second pass reads act 16..31 and weights 18..35; exactly 3 ld_start pulses and 1 job_done.
- K=3, OC=63: wgt_cnt=567>511, so err_cfg=1 and job_done at t+2, with no ld_start and no SRAM en. Repeat with K=2: same response.
- Hold pe_ready low 10 cycles in HANDOFF: tile_valid stays high, and no reads occur until pe_ready rises.
- Issue cfg_valid mid-STREAM: ignored and the config is unchanged. Assert resetn low mid-STREAM: all outputs 0 next cycle and state IDLE.
- Pulse ld_done during STREAM: the block finishes streaming both counts, then goes directly to HANDOFF.
